siu_addr_sched: RTL

//  Round-robin scheduler sharing one signed-offset address converter and one synapse memory read port among NREQ requesters.

---
 rtl/siu_addr_sched.sv | 112 +++++++++++
 1 files changed

// File: rtl/siu_addr_sched.sv
// Round-robin scheduler: picks one of NREQ requesters, converts its signed-offset
// address (optional two's-complement negation) and issues it to the synapse memory.
module siu_addr_sched #(
  parameter int NREQ = 4,
  parameter int AW   = 9,
  parameter int IDW  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ-1:0]      req_sign,
  output logic [NREQ-1:0]      req_ready,
  output logic                 mem_valid,
  output logic [AW-1:0]        mem_addr,
  output logic [IDW-1:0]       mem_id,
  input  logic                 mem_ready,
  output logic                 busy,
  output logic                 o_dbg_state,
  output logic [IDW-1:0]       o_dbg_rr_ptr
);

  // Handshakes: a transfer happens on a rising edge where valid & ready are both 1.
  // Requesters hold valid/addr/sign until ready; mem_addr/mem_id are held while
  // mem_valid=1 and mem_ready=0.
  typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IDW-1:0]   r_rr_ptr;
  logic             r_mem_valid;
  logic [AW-1:0]    r_mem_addr;
  logic [IDW-1:0]   r_mem_id;

  logic             w_found;
  logic [IDW-1:0]   w_grant;
  logic [AW-1:0]    w_sel_addr;
  logic             w_sel_sign;
  logic             w_can_accept;
  logic             w_accept;
  logic [AW-1:0]    w_conv;
  logic [IDW-1:0]   w_rr_nxt;

  function automatic int wrap_idx(input int p, input int k);
    return (p + k) % NREQ;
  endfunction

  always_comb begin
    w_found    = 1'b0;
    w_grant    = '0;
    w_sel_addr = '0;
    w_sel_sign = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!w_found && req_valid[wrap_idx(int'(r_rr_ptr), k)]) begin
        w_found    = 1'b1;
        w_grant    = IDW'(wrap_idx(int'(r_rr_ptr), k));
        w_sel_addr = req_addr[wrap_idx(int'(r_rr_ptr), k)*AW +: AW];
        w_sel_sign = req_sign[wrap_idx(int'(r_rr_ptr), k)];
      end
    end
  end

  // Reset masks acceptance so nothing is granted while rst is asserted.
  assign w_can_accept = !rst && ((r_state == IDLE) || mem_ready);
  assign w_accept     = w_can_accept && w_found;
  assign w_conv       = w_sel_sign ? (~w_sel_addr + 1'b1) : w_sel_addr;
  assign w_rr_nxt     = (w_grant == IDW'(NREQ - 1)) ? '0 : w_grant + 1'b1;

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = w_accept && (w_grant == IDW'(i));
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = ISSUE;
      ISSUE:   if (mem_ready) w_state_nxt = w_accept ? ISSUE : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_rr_ptr    <= '0;
      r_mem_valid <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_id    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_mem_valid <= 1'b1;
        r_mem_addr  <= w_conv;
        r_mem_id    <= w_grant;
        r_rr_ptr    <= w_rr_nxt;
      end else if ((r_state == ISSUE) && mem_ready) begin
        r_mem_valid <= 1'b0;
      end
    end
  end

  assign mem_valid    = r_mem_valid;
  assign mem_addr     = r_mem_addr;
  assign mem_id       = r_mem_id;
  assign busy         = (r_state == ISSUE);
  assign o_dbg_state  = r_state;
  assign o_dbg_rr_ptr = r_rr_ptr;

endmodule
